// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: N AXI-Stream masters share one downstream slave.
// Grant is decided one cycle after a request is seen; m_tready stalls the granted source in place.
module axis_rr_arbiter #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic [N-1:0]           s_tvalid,
  input  logic [N*DATA_W-1:0]    s_tdata,
  input  logic [N-1:0]           s_tlast,
  output logic [N-1:0]           s_tready,
  output logic                   m_tvalid,
  output logic [DATA_W-1:0]      m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic                   busy,
  output logic [CNT_W-1:0]       beat_cnt,
  output logic [CNT_W-1:0]       pkt_cnt
);

  localparam int GW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [GW-1:0]       ptr;
  logic [GW-1:0]       pick;
  logic [GW-1:0]       cand;
  logic                pick_found;
  logic                g_vld;
  logic [DATA_W-1:0]   g_dat;
  logic                g_last;
  logic                accept;
  logic                pkt_done;

  // Search starts just after the last completed grant, so that source gets lowest priority.
  always_comb begin
    pick       = '0;
    cand       = '0;
    pick_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = GW'((int'(ptr) + k) % N);
      if (!pick_found && s_tvalid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    g_vld  = 1'b0;
    g_dat  = '0;
    g_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_id == GW'(i)) begin
        g_vld  = s_tvalid[i];
        g_dat  = s_tdata[i*DATA_W +: DATA_W];
        g_last = s_tlast[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    busy     = 1'b0;
    accept   = 1'b0;
    pkt_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = XFER;
        end
      end
      XFER: begin
        busy     = 1'b1;
        m_tvalid = g_vld;
        if (g_vld) begin
          m_tdata = g_dat;
          m_tlast = g_last;
        end
        for (int i = 0; i < N; i++) begin
          s_tready[i] = (grant_id == GW'(i)) && m_tready;
        end
        accept = g_vld && m_tready;
        if (accept && g_last) begin
          pkt_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // beat_cnt keeps the finished packet's length visible until the next grant clears it.
  always_ff @(posedge clk) begin
    if (areset) begin
      ptr      <= GW'(N - 1);
      grant_id <= '0;
      beat_cnt <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (state_q == IDLE && pick_found) begin
        grant_id <= pick;
        beat_cnt <= '0;
      end
      if (accept && (beat_cnt != '1)) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (pkt_done) begin
        ptr     <= grant_id;
        pkt_cnt <= pkt_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: packet queues per source plus a rule-level arbitration model.
module tb_axis_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int GW = 2;
  localparam int VW = 1 + GW + 1 + DW + 1 + N + CW + CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              areset;
  logic [N-1:0]      s_tvalid;
  logic [N*DW-1:0]   s_tdata;
  logic [N-1:0]      s_tlast;
  logic [N-1:0]      s_tready;
  logic              m_tvalid;
  logic [DW-1:0]     m_tdata;
  logic              m_tlast;
  logic              m_tready;
  logic [GW-1:0]     grant_id;
  logic              busy;
  logic [CW-1:0]     beat_cnt;
  logic [CW-1:0]     pkt_cnt;

  axis_rr_arbiter #(.N(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .areset(areset),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant_id(grant_id), .busy(busy), .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Source side: each requester owns a queue of pending beats.
  bit [7:0] q_dat [N][$];
  bit       q_last[N][$];
  int       bub[N];

  // Reference: who holds the lock, who finished last, and the counters.
  bit md_busy;
  int md_g, md_ptr, md_beats, md_pkts;

  logic          exp_vld, exp_last;
  logic [DW-1:0] exp_dat;
  logic [N-1:0]  exp_rdy;
  logic [VW-1:0] obs_v, exp_v;

  function automatic bit pending();
    bit p;
    p = md_busy;
    for (int i = 0; i < N; i++) if (q_dat[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic push_pkt(input int src, input int len);
    for (int b = 0; b < len; b++) begin
      q_dat[src].push_back(8'($urandom));
      q_last[src].push_back(b == len - 1);
    end
  endtask

  task automatic drive(input bit rdy, input bit rst);
    bit hold;
    @(negedge clk);
    areset   = rst;
    m_tready = rdy;
    for (int i = 0; i < N; i++) begin
      hold = md_busy && (md_g == i) && (bub[i] > 0);
      if (hold) bub[i]--;
      s_tvalid[i] = (q_dat[i].size() > 0) && !hold;
      s_tdata[i*DW +: DW] = '0;
      s_tlast[i] = 1'b0;
      if (s_tvalid[i]) begin
        s_tdata[i*DW +: DW] = q_dat[i][0];
        s_tlast[i] = q_last[i][0];
      end
    end
    #1;
    exp_rdy = '0; exp_vld = 1'b0; exp_dat = '0; exp_last = 1'b0;
    if (md_busy) begin
      exp_rdy[md_g] = m_tready;
      if (s_tvalid[md_g]) begin
        exp_vld  = 1'b1;
        exp_dat  = q_dat[md_g][0];
        exp_last = q_last[md_g][0];
      end
    end
    obs_v = {busy, grant_id, m_tvalid, m_tdata, m_tlast, s_tready, beat_cnt, pkt_cnt};
    exp_v = {md_busy, GW'(md_g), exp_vld, exp_dat, exp_last, exp_rdy, CW'(md_beats), CW'(md_pkts)};
  endtask

  // Applies the arbitration rules for the coming clock edge, then waits for it.
  task automatic commit();
    bit found;
    int sel;
    if (areset) begin
      md_busy = 0; md_ptr = N - 1; md_g = 0; md_beats = 0; md_pkts = 0;
      for (int i = 0; i < N; i++) bub[i] = 0;
    end else if (!md_busy) begin
      found = 0; sel = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && s_tvalid[(md_ptr + k) % N]) begin
          found = 1; sel = (md_ptr + k) % N;
        end
      end
      if (found) begin
        md_g = sel; md_busy = 1; md_beats = 0;
      end
    end else if (exp_vld && m_tready) begin
      void'(q_dat[md_g].pop_front());
      void'(q_last[md_g].pop_front());
      if (md_beats < (1 << CW) - 1) md_beats++;
      if (exp_last) begin
        md_ptr = md_g; md_pkts = (md_pkts + 1) % (1 << CW); md_busy = 0;
      end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 15; c++) begin
      drive(1'b0, c < 10);
      if (c > 0) begin
        checks++;
        if (obs_v !== exp_v) begin
          failures++;
          $display("FAIL reset_idle c=%0d got=%h want=%h", c, obs_v, exp_v);
        end
      end
      commit();
    end
  endtask

  task automatic test_single();
    bit [7:0] pat[4];
    bit [31:0] got;
    int nacc, t_last;
    pat = '{8'h03, 8'h07, 8'h0A, 8'h0F};
    for (int b = 0; b < 4; b++) begin
      q_dat[2].push_back(pat[b]);
      q_last[2].push_back(b == 3);
    end
    got = '0; nacc = 0; t_last = -1;
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL single_cycle c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (c == 1) begin
        checks++;
        if (grant_id !== 2'd2 || busy !== 1'b1) begin
          failures++;
          $display("FAIL single_grant got id=%0d busy=%b want id=2 busy=1", grant_id, busy);
        end
      end
      if (t_last >= 0 && c == t_last + 1) begin
        checks++;
        if (busy !== 1'b0 || beat_cnt !== 16'd4 || pkt_cnt !== 16'd1) begin
          failures++;
          $display("FAIL single_end got busy=%b beats=%0d pkts=%0d want 0 4 1", busy, beat_cnt, pkt_cnt);
        end
      end
      if (m_tvalid && m_tready) begin
        got = {got[23:0], m_tdata};
        nacc++;
        if (m_tlast) t_last = c;
      end
      commit();
    end
    checks++;
    if (got !== 32'h03070A0F || nacc != 4 || t_last != 4) begin
      failures++;
      $display("FAIL single_data got=%h n=%0d last_c=%0d want 03070a0f n=4 last_c=4", got, nacc, t_last);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    bit prev_busy, ok;
    drive(1'b0, 1'b1);
    commit();
    for (int s = 0; s < N; s++) begin
      push_pkt(s, 2);
      push_pkt(s, 2);
    end
    prev_busy = 0;
    for (int c = 0; c < 60 && md_pkts < 6; c++) begin
      drive(1'b1, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL rr_cycle c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (busy && !prev_busy) order.push_back(int'(grant_id));
      prev_busy = busy;
      commit();
    end
    #1;
    ok = (order.size() >= 6);
    for (int i = 0; i < 6 && ok; i++) if (order[i] != i % N) ok = 0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rr_order got=%p want 0,1,2,3,0,1", order);
    end
    checks++;
    if (pkt_cnt !== 16'd6) begin
      failures++;
      $display("FAIL rr_pkt_cnt got=%0d want=6", pkt_cnt);
    end
    for (int c = 0; c < 60 && pending(); c++) begin
      drive(1'b1, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL rr_drain c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      commit();
    end
  endtask

  task automatic test_backpressure();
    int pushed, accepted, bub_pkt, s, len;
    pushed = 0; accepted = 0; bub_pkt = -1;
    for (int c = 0; c < 900; c++) begin
      if (c < 200 && $urandom_range(0, 5) == 0) begin
        s = $urandom_range(0, N - 1);
        len = $urandom_range(1, 4);
        push_pkt(s, len);
        pushed += len;
      end
      if (md_busy && md_beats >= 1 && bub_pkt != md_pkts) begin
        bub[md_g] = 2;
        bub_pkt = md_pkts;
      end
      drive(c % 2 == 0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL bp_cycle c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (m_tvalid && m_tready) accepted++;
      commit();
      if (c >= 200 && !pending()) break;
    end
    checks++;
    if (accepted != pushed) begin
      failures++;
      $display("FAIL bp_beats got=%0d want=%0d", accepted, pushed);
    end
  endtask

  task automatic test_reset_mid();
    int order[$];
    bit prev_busy;
    push_pkt(1, 4);
    for (int c = 0; c < 20 && !(md_busy && md_beats == 2); c++) begin
      drive(1'b1, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL rmid_cycle c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      commit();
    end
    #1;
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd1 || beat_cnt !== 16'd2) begin
      failures++;
      $display("FAIL rmid_setup got busy=%b id=%0d beats=%0d want 1 1 2", busy, grant_id, beat_cnt);
    end
    q_dat[1].delete();
    q_last[1].delete();
    drive(1'b0, 1'b1);
    commit();
    push_pkt(0, 2);
    push_pkt(1, 2);
    prev_busy = 0;
    for (int c = 0; c < 30 && pending(); c++) begin
      drive(1'b1, 1'b0);
      if (c == 0) begin
        checks++;
        if (busy !== 1'b0 || pkt_cnt !== 16'd0 || s_tready !== 4'b0 || m_tvalid !== 1'b0) begin
          failures++;
          $display("FAIL rmid_after got busy=%b pkts=%0d rdy=%b vld=%b want 0 0 0000 0",
                   busy, pkt_cnt, s_tready, m_tvalid);
        end
      end
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL rmid_resume c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (busy && !prev_busy) order.push_back(int'(grant_id));
      prev_busy = busy;
      commit();
    end
    checks++;
    if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin
      failures++;
      $display("FAIL rmid_order got=%p want 0,1", order);
    end
  endtask

  task automatic test_b2b();
    int last_c, base, k;
    for (int p = 0; p < 8; p++) push_pkt(0, 1);
    last_c = -1; base = md_pkts; k = 0;
    for (int c = 0; c < 40 && pending(); c++) begin
      drive(1'b1, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL b2b_cycle c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (m_tvalid && m_tready) begin
        if (last_c >= 0) begin
          checks++;
          if (c - last_c != 2 || pkt_cnt !== CW'(base + k)) begin
            failures++;
            $display("FAIL b2b_rate got gap=%0d pkts=%0d want gap=2 pkts=%0d", c - last_c, pkt_cnt, base + k);
          end
        end
        last_c = c;
        k++;
      end
      commit();
    end
    #1;
    checks++;
    if (k != 8 || pkt_cnt !== CW'(base + 8)) begin
      failures++;
      $display("FAIL b2b_total got beats=%0d pkts=%0d want 8 %0d", k, pkt_cnt, base + 8);
    end
  endtask

  initial begin
    areset = 1'b1; s_tvalid = '0; s_tdata = '0; s_tlast = '0; m_tready = 1'b0;
    md_busy = 0; md_ptr = N - 1; md_g = 0; md_beats = 0; md_pkts = 0;
    for (int i = 0; i < N; i++) bub[i] = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_b2b();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
